regfile_write_queue: RTL and testbench

Write-side front end for the MIPS register file: collects writeback results from the ALU and load paths, buffers them in a small FIFO, and retires one write per cycle onto the register file's write port (`regWrite` / `write_back` / write address) with a valid/ready handshake. Its per-register pending-write scoreboard tells decode when a source register still has a write in flight. It sits between the execute/memory stages and the register file.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 107 ++++++++++
 rtl/regfile_write_queue.sv | 182 ++++++++++++++++++
 tb/tb_regfile_write_queue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS register-file write path.
//   REG_ZERO    : register number of the hardwired-zero register ($zero)
//   wb_entry_t  : one writeback request (target register + value)
//   wq_state_t  : write-queue drain state machine encoding
package mips_pkg;

    localparam int MIPS_ADDR_W = 5;
    localparam int MIPS_DATA_W = 32;
    localparam int REG_ZERO    = 0;

    typedef struct packed {
        logic [MIPS_ADDR_W-1:0] addr;
        logic [MIPS_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } wq_state_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: storage for the register-file write queue.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   push, push_addr, push_data write a new entry at the tail (ignored when full)
//   pop                        drop the head entry (ignored when empty)
//   empty, full, occupancy     fill status
//   head_addr, head_data       oldest entry, valid only when !empty
//   entry_valid, entry_addrs   per-slot valid bit and target register (flattened)
//   entry_data, head_ptr       only with REGFILE_WQ_FWD_EN: per-slot values and
//                              head slot index, so the top can find the newest match
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [ADDR_W-1:0]       push_addr,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic                    empty,
    output logic                    full,
    output logic [PTR_W:0]          occupancy,
    output logic [ADDR_W-1:0]       head_addr,
    output logic [DATA_W-1:0]       head_data,
    output logic [DEPTH-1:0]        entry_valid,
    output logic [DEPTH*ADDR_W-1:0] entry_addrs
`ifdef REGFILE_WQ_FWD_EN
    ,
    output logic [DEPTH*DATA_W-1:0] entry_data,
    output logic [PTR_W-1:0]        head_ptr
`endif
);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [DEPTH-1:0]  valid;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers, occupancy and the per-slot valid bits that feed the scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (do_push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: a slot is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        entry_addrs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addrs[i*ADDR_W +: ADDR_W] = mem_addr[i];
        end
    end

`ifdef REGFILE_WQ_FWD_EN
    always_comb begin
        entry_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_data[i*DATA_W +: DATA_W] = mem_data[i];
        end
    end
    assign head_ptr = rd_ptr;
`endif

    assign occupancy   = count;
    assign entry_valid = valid;
    assign head_addr   = mem_addr[rd_ptr];
    assign head_data   = mem_data[rd_ptr];

endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: write-side front end of the MIPS register file.
// Collects ALU and load writeback offers (load has priority), buffers them in
// wb_fifo and retires one per cycle on the register-file write port. A pending
// write scoreboard reports whether decode source registers have writes in flight.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   alu_valid/alu_addr/alu_data/alu_ready  ALU result offer handshake
//   ld_valid/ld_addr/ld_data/ld_ready      load result offer handshake
//   rf_reg_write/rf_addr/rf_data/rf_ready  write port toward the register file
//   rd_addr1/rd_addr2, rd_busy1/rd_busy2   decode source registers and busy flags
//   drain_req, drained                  stop accepting and empty the queue
//   retired_cnt                         wrapping count of retired writes
// Optional feature macro REGFILE_WQ_FWD_EN adds fwd_hit1/fwd_data1 and
// fwd_hit2/fwd_data2, giving decode the newest queued value for each source.
module regfile_write_queue
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = MIPS_DATA_W,
    parameter int ADDR_W = MIPS_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              rf_reg_write,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    input  logic              rf_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              drain_req,
    output logic              drained,
    output logic [15:0]       retired_cnt
`ifdef REGFILE_WQ_FWD_EN
    ,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

    wq_state_t              state_q;
    wq_state_t              state_d;
    logic                   empty;
    logic                   full;
    logic [PTR_W:0]         occupancy;
    logic [ADDR_W-1:0]      head_addr;
    logic [DATA_W-1:0]      head_data;
    logic [DEPTH-1:0]       entry_valid;
    logic [DEPTH*ADDR_W-1:0] entry_addrs;
    logic                   ld_take;
    logic                   alu_take;
    logic                   push;
    logic [ADDR_W-1:0]      push_addr;
    logic [DATA_W-1:0]      push_data;
    logic                   pop;
    logic [ADDR_W-1:0]      last_addr;
    logic [DATA_W-1:0]      last_data;
`ifdef REGFILE_WQ_FWD_EN
    logic [DEPTH*DATA_W-1:0] entry_data;
    logic [PTR_W-1:0]        head_ptr;
`endif

    // Load wins arbitration; an ALU offer is only taken when no load is offered.
    assign ld_ready  = !full && (state_q == RUN);
    assign alu_ready = !full && !ld_valid && (state_q == RUN);
    assign ld_take   = ld_valid && ld_ready;
    assign alu_take  = alu_valid && alu_ready;
    assign push_addr = ld_take ? ld_addr : alu_addr;
    assign push_data = ld_take ? ld_data : alu_data;
    // Writes to $zero are acknowledged but dropped.
    assign push      = (ld_take && (ld_addr != ZERO_REG)) ||
                       (alu_take && (alu_addr != ZERO_REG));
    assign pop       = !empty && rf_ready;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_addr   (push_addr),
        .push_data   (push_data),
        .pop         (pop),
        .empty       (empty),
        .full        (full),
        .occupancy   (occupancy),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_addrs (entry_addrs)
`ifdef REGFILE_WQ_FWD_EN
        ,
        .entry_data  (entry_data),
        .head_ptr    (head_ptr)
`endif
    );

    // When the queue empties the write port keeps showing the last retired entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_addr   <= '0;
            last_data   <= '0;
            retired_cnt <= '0;
        end else if (pop) begin
            last_addr   <= head_addr;
            last_data   <= head_data;
            retired_cnt <= retired_cnt + 16'd1;
        end
    end

    assign rf_reg_write = !empty;
    assign rf_addr      = empty ? last_addr : head_addr;
    assign rf_data      = empty ? last_data : head_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN ends once the queue is empty after this cycle's pop; no pushes occur in DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN:   if (empty || ((occupancy == (PTR_W+1)'(1)) && pop)) state_d = DONE;
            DONE:    if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign drained = (state_q == DONE);

    always_comb begin
        rd_busy1 = 1'b0;
        rd_busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addrs[i*ADDR_W +: ADDR_W] == rd_addr1)) rd_busy1 = 1'b1;
            if (entry_valid[i] && (entry_addrs[i*ADDR_W +: ADDR_W] == rd_addr2)) rd_busy2 = 1'b1;
        end
        if (rd_addr1 == ZERO_REG) rd_busy1 = 1'b0;
        if (rd_addr2 == ZERO_REG) rd_busy2 = 1'b0;
    end

`ifdef REGFILE_WQ_FWD_EN
    // Walk from head (oldest) to tail so the last match found is the newest value.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PTR_W'(k);
            if (entry_valid[idx] && (entry_addrs[idx*ADDR_W +: ADDR_W] == rd_addr1))
                fwd_data1 = entry_data[idx*DATA_W +: DATA_W];
            if (entry_valid[idx] && (entry_addrs[idx*ADDR_W +: ADDR_W] == rd_addr2))
                fwd_data2 = entry_data[idx*DATA_W +: DATA_W];
        end
    end
    assign fwd_hit1 = rd_busy1;
    assign fwd_hit2 = rd_busy2;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: self-checking bench for regfile_write_queue.
// A queue-based reference model predicts every output each cycle; directed
// steps follow the intended use cases, then a randomized phase runs.
// Build with REGFILE_WQ_FWD_EN defined to also check the forwarding outputs.
module tb_regfile_write_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              rf_ready;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              drain_req;
    logic              drained;
    logic [15:0]       retired_cnt;
`ifdef REGFILE_WQ_FWD_EN
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;
`endif

    int checks   = 0;
    int failures = 0;

    regfile_write_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .rf_reg_write (rf_reg_write),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .rf_ready     (rf_ready),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rd_busy1     (rd_busy1),
        .rd_busy2     (rd_busy2),
        .drain_req    (drain_req),
        .drained      (drained),
        .retired_cnt  (retired_cnt)
`ifdef REGFILE_WQ_FWD_EN
        ,
        .fwd_hit1     (fwd_hit1),
        .fwd_data1    (fwd_data1),
        .fwd_hit2     (fwd_hit2),
        .fwd_data2    (fwd_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of pending writes in acceptance order.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              mq[$];
    logic [15:0]       m_cnt;
    int                m_mode;
    logic [ADDR_W-1:0] m_last_addr;
    logic [DATA_W-1:0] m_last_data;

    task automatic model_reset();
        mq.delete();
        m_cnt       = 16'd0;
        m_mode      = 0;
        m_last_addr = '0;
        m_last_data = '0;
    endtask

    function automatic logic m_busy(logic [ADDR_W-1:0] a);
        if (a == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] m_newest(logic [ADDR_W-1:0] a);
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].addr == a) return mq[i].data;
        return '0;
    endfunction

    function automatic logic m_ld_ready();
        return (mq.size() < DEPTH) && (m_mode == 0);
    endfunction

    function automatic logic m_alu_ready();
        return (mq.size() < DEPTH) && !ld_valid && (m_mode == 0);
    endfunction

    task automatic model_advance();
        logic ldr;
        logic alur;
        ldr  = m_ld_ready();
        alur = m_alu_ready();
        if (mq.size() != 0 && rf_ready) begin
            m_last_addr = mq[0].addr;
            m_last_data = mq[0].data;
            void'(mq.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        if (ld_valid && ldr) begin
            if (ld_addr != '0) mq.push_back('{ld_addr, ld_data});
        end else if (alu_valid && alur) begin
            if (alu_addr != '0) mq.push_back('{alu_addr, alu_data});
        end
        case (m_mode)
            0:       if (drain_req) m_mode = 1;
            1:       if (mq.size() == 0) m_mode = 2;
            default: if (!drain_req) m_mode = 0;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(
        input logic rst,
        input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ldd,
        input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
        input logic rr, input logic dr,
        input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
        reset     = rst;
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = ldd;
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        rf_ready  = rr;
        drain_req = dr;
        rd_addr1  = r1;
        rd_addr2  = r2;
    endtask

    // Called just after a falling edge with inputs applied: check, then advance.
    task automatic do_cycle();
        #1;
        if (reset) model_reset();
        checkOutput("ld_ready",     32'(ld_ready),     32'(m_ld_ready()));
        checkOutput("alu_ready",    32'(alu_ready),    32'(m_alu_ready()));
        checkOutput("rf_reg_write", 32'(rf_reg_write), 32'(mq.size() != 0));
        checkOutput("rf_addr",      32'(rf_addr),      32'((mq.size() != 0) ? mq[0].addr : m_last_addr));
        checkOutput("rf_data",      rf_data,           (mq.size() != 0) ? mq[0].data : m_last_data);
        checkOutput("rd_busy1",     32'(rd_busy1),     32'(m_busy(rd_addr1)));
        checkOutput("rd_busy2",     32'(rd_busy2),     32'(m_busy(rd_addr2)));
        checkOutput("drained",      32'(drained),      32'(m_mode == 2));
        checkOutput("retired_cnt",  32'(retired_cnt),  32'(m_cnt));
`ifdef REGFILE_WQ_FWD_EN
        checkOutput("fwd_hit1",     32'(fwd_hit1),     32'(m_busy(rd_addr1)));
        checkOutput("fwd_hit2",     32'(fwd_hit2),     32'(m_busy(rd_addr2)));
        if (m_busy(rd_addr1)) checkOutput("fwd_data1", fwd_data1, m_newest(rd_addr1));
        if (m_busy(rd_addr2)) checkOutput("fwd_data2", fwd_data2, m_newest(rd_addr2));
`endif
        @(posedge clk);
        if (!reset) model_advance();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rr, input logic dr, input logic [ADDR_W-1:0] r1);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, rr, dr, r1, 0);
            do_cycle();
        end
    endtask

    initial begin
        logic drain_hold;
        logic rst_r;
        model_reset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_cycle();
        do_cycle();

        $display("[TB] single ALU write to r9");
        applyStimulus(0, 0, 0, 0, 1, 5'd9, 32'hAA, 1, 0, 5'd9, 0);
        do_cycle();
        idle(2, 1, 0, 5'd9);

        $display("[TB] load and ALU offered together");
        applyStimulus(0, 1, 5'd10, 32'h11, 1, 5'd11, 32'h22, 1, 0, 5'd10, 5'd11);
        do_cycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd11, 32'h22, 1, 0, 5'd10, 5'd11);
        do_cycle();
        idle(2, 1, 0, 0);

        $display("[TB] fill with register file stalled");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 1, 5'(i), 32'h100 + 32'(i), 0, 0, 0, 0, 0, 5'd3, 5'd5);
            do_cycle();
        end
        applyStimulus(0, 1, 5'd5, 32'h105, 0, 0, 0, 0, 0, 5'd3, 5'd5);
        do_cycle();
        idle(6, 1, 0, 5'd3);

        $display("[TB] duplicate targets and writes to r0");
        applyStimulus(0, 0, 0, 0, 1, 5'd12, 32'h1, 0, 0, 5'd12, 0);
        do_cycle();
        applyStimulus(0, 1, 5'd12, 32'h2, 0, 0, 0, 0, 0, 5'd12, 0);
        do_cycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 0, 0, 5'd12, 5'd0);
        do_cycle();
        idle(4, 1, 0, 5'd12);

        $display("[TB] drain with two queued");
        applyStimulus(0, 1, 5'd20, 32'h20, 0, 0, 0, 0, 0, 5'd20, 0);
        do_cycle();
        applyStimulus(0, 1, 5'd21, 32'h21, 0, 0, 0, 0, 0, 5'd20, 5'd21);
        do_cycle();
        idle(5, 1, 1, 5'd21);
        idle(2, 1, 0, 5'd21);

        $display("[TB] reset with entries queued");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 5'(22 + i), 32'(i), 0, 0, 0, 0, 0, 5'd22, 5'd24);
            do_cycle();
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd22, 5'd24);
        do_cycle();
        idle(1, 0, 0, 5'd22);

        $display("[TB] newest value for repeated target");
        applyStimulus(0, 1, 5'd13, 32'h5, 0, 0, 0, 0, 0, 5'd13, 0);
        do_cycle();
        applyStimulus(0, 0, 0, 0, 1, 5'd13, 32'h7, 0, 0, 5'd13, 0);
        do_cycle();
        idle(1, 0, 0, 5'd13);
        idle(3, 1, 0, 5'd13);

        $display("[TB] randomized traffic");
        drain_hold = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 29) == 0) drain_hold = ~drain_hold;
            rst_r = ($urandom_range(0, 199) == 0);
            applyStimulus(rst_r,
                          1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)), $urandom,
                          1'($urandom_range(0, 1)),      5'($urandom_range(0, 15)), $urandom,
                          1'($urandom_range(0, 3) != 0), drain_hold,
                          5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
